// File: rtl/udcount_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udcount_pkg
// Description : Shared FSM, status and register-address constants for the
//               up/down counter configuration loader and its peers.
// Revision    : 1.0 - initial release
// ============================================================================
package udcount_pkg;

    typedef logic [3:0] state_t;
    typedef logic [1:0] status_t;

    localparam state_t S_IDLE  = 4'd0;
    localparam state_t S_CAPT  = 4'd1;
    localparam state_t S_CHECK = 4'd2;
    localparam state_t S_WR    = 4'd3;
    localparam state_t S_RD    = 4'd4;
    localparam state_t S_START = 4'd5;
    localparam state_t S_WAIT  = 4'd6;
    localparam state_t S_DONE  = 4'd7;

    localparam status_t ST_OK      = 2'd0;
    localparam status_t ST_RANGE   = 2'd1;
    localparam status_t ST_VERIFY  = 2'd2;
    localparam status_t ST_TIMEOUT = 2'd3;

    localparam logic [1:0] ADDR_PLR = 2'd0;
    localparam logic [1:0] ADDR_ULR = 2'd1;
    localparam logic [1:0] ADDR_LLR = 2'd2;
    localparam logic [1:0] ADDR_CCR = 2'd3;

    function automatic logic [7:0] reg_sel(input logic [1:0] a,
                                           input logic [7:0] plr, input logic [7:0] ulr,
                                           input logic [7:0] llr, input logic [7:0] ccr);
        case (a)
            ADDR_PLR: reg_sel = plr;
            ADDR_ULR: reg_sel = ulr;
            ADDR_LLR: reg_sel = llr;
            default:  reg_sel = ccr;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/udcount_cfg_loader_timer.sv
`default_nettype none
// ============================================================================
// Module      : udcount_cfg_timer
// Description : WAIT-phase cycle timer; o_term flags the last allowed cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module udcount_cfg_timer #(
    parameter int TIMEOUT_CYCLES = 4096
)(
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_term
);

    localparam int W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Terminal one cycle early so the FSM leaves WAIT as the count reaches the limit.
    assign o_term = (TIMEOUT_CYCLES != 0) && i_en && (r_count == W'(TIMEOUT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/udcount_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : udcount_cfg_loader
// Description : Accepts one counter configuration, range-checks, writes and
//               optionally verifies it, starts the counter and reports status.
// Revision    : 1.0 - initial release
// ============================================================================
module udcount_cfg_loader
    import udcount_pkg::*;
#(
    parameter int   TIMEOUT_CYCLES = 4096,
    parameter logic VERIFY_DEFAULT = 1'b0
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_plr,
    input  logic [7:0] cfg_ulr,
    input  logic [7:0] cfg_llr,
    input  logic [7:0] cfg_ccr,
    input  logic       cfg_verify,
    output logic       bus_ncs,
    output logic       bus_nwr,
    output logic       bus_nrd,
    output logic [1:0] bus_a,
    output logic [7:0] bus_din,
    input  logic [7:0] bus_dout,
    output logic       cnt_start,
    input  logic       cnt_ec,
    output logic       busy,
    output logic       done,
    output logic [1:0] status
);

    state_t     r_state;
    logic [1:0] r_idx;
    logic [7:0] r_plr, r_ulr, r_llr, r_ccr;
    logic       r_verify;
    logic       r_mis;

    logic       r_cfg_ready, r_bus_ncs, r_bus_nwr, r_bus_nrd, r_cnt_start, r_busy, r_done;
    logic [1:0] r_bus_a;
    logic [7:0] r_bus_din;
    status_t    r_status;

    state_t     w_nxt;
    logic [1:0] w_nxt_idx;
    status_t    w_result;
    logic       w_accept;
    logic       w_rd_bad;
    logic       w_term;
    logic [7:0] w_cur_reg;
    logic [7:0] w_nxt_reg;

    udcount_cfg_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (r_state == S_START),
        .i_en   (r_state == S_WAIT),
        .o_term (w_term)
    );

    assign w_accept  = cfg_valid && r_cfg_ready;
    assign w_cur_reg = reg_sel(r_idx, r_plr, r_ulr, r_llr, r_ccr);
    assign w_nxt_reg = reg_sel(w_nxt_idx, r_plr, r_ulr, r_llr, r_ccr);
    assign w_rd_bad  = (r_state == S_RD) && (bus_dout != w_cur_reg);

    always_comb begin
        w_nxt     = r_state;
        w_nxt_idx = r_idx;
        w_result  = ST_OK;
        case (r_state)
            S_IDLE:  if (w_accept) w_nxt = S_CAPT;
            S_CAPT:  w_nxt = S_CHECK;
            S_CHECK: begin
                w_nxt_idx = 2'd0;
                if ((r_llr <= r_plr) && (r_plr <= r_ulr)) begin
                    w_nxt = S_WR;
                end else begin
                    w_nxt    = S_DONE;
                    w_result = ST_RANGE;
                end
            end
            S_WR: begin
                w_nxt_idx = r_idx + 2'd1;
                if (r_idx == ADDR_CCR) w_nxt = r_verify ? S_RD : S_START;
            end
            S_RD: begin
                w_nxt_idx = r_idx + 2'd1;
                if (r_idx == ADDR_CCR) begin
                    if (r_mis || w_rd_bad) begin
                        w_nxt    = S_DONE;
                        w_result = ST_VERIFY;
                    end else begin
                        w_nxt = S_START;
                    end
                end
            end
            S_START: w_nxt = S_WAIT;
            // End-of-count outranks a coincident timeout.
            S_WAIT: begin
                if (cnt_ec) begin
                    w_nxt = S_DONE;
                end else if (w_term) begin
                    w_nxt    = S_DONE;
                    w_result = ST_TIMEOUT;
                end
            end
            S_DONE:  w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= 2'd0;
            r_plr       <= 8'd0;
            r_ulr       <= 8'd0;
            r_llr       <= 8'd0;
            r_ccr       <= 8'd0;
            r_verify    <= VERIFY_DEFAULT;
            r_mis       <= 1'b0;
            r_cfg_ready <= 1'b0;
            r_bus_ncs   <= 1'b1;
            r_bus_nwr   <= 1'b1;
            r_bus_nrd   <= 1'b1;
            r_bus_a     <= ADDR_PLR;
            r_bus_din   <= 8'd0;
            r_cnt_start <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_status    <= ST_OK;
        end else begin
            r_state <= w_nxt;
            r_idx   <= w_nxt_idx;
            if (w_accept) begin
                r_plr    <= cfg_plr;
                r_ulr    <= cfg_ulr;
                r_llr    <= cfg_llr;
                r_ccr    <= cfg_ccr;
                r_verify <= cfg_verify;
            end
            if (r_state == S_CHECK) r_mis <= 1'b0;
            else if (w_rd_bad)      r_mis <= 1'b1;

            r_cfg_ready <= (w_nxt == S_IDLE);
            r_bus_ncs   <= !((w_nxt == S_WR) || (w_nxt == S_RD));
            r_bus_nwr   <= (w_nxt != S_WR);
            r_bus_nrd   <= (w_nxt != S_RD);
            r_bus_a     <= ((w_nxt == S_WR) || (w_nxt == S_RD)) ? w_nxt_idx : ADDR_PLR;
            r_bus_din   <= (w_nxt == S_WR) ? w_nxt_reg : 8'd0;
            r_cnt_start <= (w_nxt == S_START);
            r_busy      <= (w_nxt != S_IDLE);
            r_done      <= (w_nxt == S_DONE);
            if (w_nxt == S_DONE) r_status <= w_result;
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign bus_ncs   = r_bus_ncs;
    assign bus_nwr   = r_bus_nwr;
    assign bus_nrd   = r_bus_nrd;
    assign bus_a     = r_bus_a;
    assign bus_din   = r_bus_din;
    assign cnt_start = r_cnt_start;
    assign busy      = r_busy;
    assign done      = r_done;
    assign status    = r_status;

endmodule
`default_nettype wire

// File: tb/tb_udcount_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_udcount_cfg_loader
// Description : Directed self-checking bench with a small counter-side model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udcount_cfg_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid, cfg_ready, cfg_verify;
    logic [7:0] cfg_plr, cfg_ulr, cfg_llr, cfg_ccr;
    logic       bus_ncs, bus_nwr, bus_nrd;
    logic [1:0] bus_a;
    logic [7:0] bus_din, bus_dout;
    logic       cnt_start, cnt_ec, busy, done;
    logic [1:0] status;

    int checks = 0;
    int failures = 0;

    udcount_cfg_loader #(
        .TIMEOUT_CYCLES (16),
        .VERIFY_DEFAULT (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_plr    (cfg_plr),
        .cfg_ulr    (cfg_ulr),
        .cfg_llr    (cfg_llr),
        .cfg_ccr    (cfg_ccr),
        .cfg_verify (cfg_verify),
        .bus_ncs    (bus_ncs),
        .bus_nwr    (bus_nwr),
        .bus_nrd    (bus_nrd),
        .bus_a      (bus_a),
        .bus_din    (bus_din),
        .bus_dout   (bus_dout),
        .cnt_start  (cnt_start),
        .cnt_ec     (cnt_ec),
        .busy       (busy),
        .done       (done),
        .status     (status)
    );

    always #5 clk = ~clk;

    // Counter model: register file, sticky end-of-count cleared by start.
    logic [7:0] mem [4];
    logic       corrupt_ulr = 1'b0;
    logic       ec_auto = 1'b0;
    logic       ec_force = 1'b0;
    logic [3:0] ec_tmr = 4'd0;
    logic       ec_q = 1'b0;

    assign cnt_ec   = ec_q;
    assign bus_dout = (!bus_ncs && !bus_nrd) ?
                      ((corrupt_ulr && bus_a == 2'd1) ? 8'h21 : mem[bus_a]) : 8'h00;

    always @(posedge clk) begin
        if (!bus_ncs && !bus_nwr) mem[bus_a] <= bus_din;
        if (cnt_start) begin
            ec_q   <= 1'b0;
            ec_tmr <= ec_auto ? 4'd3 : 4'd0;
        end else begin
            if (ec_tmr != 4'd0) ec_tmr <= ec_tmr - 4'd1;
            if (ec_tmr == 4'd1 || ec_force) ec_q <= 1'b1;
        end
    end

    // Bus monitor, sampled mid-cycle.
    int cyc = 0;
    int acc_cyc = 0;
    int n_wr = 0, n_rd = 0, n_start = 0, n_cs = 0, n_overlap = 0;
    int start_rel = -1;
    logic [1:0] wr_a [64];
    logic [7:0] wr_d [64];
    int         wr_rel [64];
    logic [1:0] rd_a [64];
    int         rd_rel [64];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cfg_valid && cfg_ready) acc_cyc = cyc + 1;
        if (!bus_ncs) n_cs = n_cs + 1;
        if (!bus_nwr && !bus_nrd) n_overlap = n_overlap + 1;
        if (!bus_ncs && !bus_nwr && n_wr < 64) begin
            wr_a[n_wr] = bus_a; wr_d[n_wr] = bus_din; wr_rel[n_wr] = cyc - acc_cyc;
            n_wr = n_wr + 1;
        end
        if (!bus_ncs && !bus_nrd && n_rd < 64) begin
            rd_a[n_rd] = bus_a; rd_rel[n_rd] = cyc - acc_cyc;
            n_rd = n_rd + 1;
        end
        if (cnt_start) begin
            start_rel = cyc - acc_cyc;
            n_start = n_start + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] p, input logic [7:0] u, input logic [7:0] l,
                        input logic [7:0] c, input logic v);
        int n = 0;
        while (!cfg_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cfg_ready_wait", 32'(cfg_ready), 32'd1);
        cfg_plr = p; cfg_ulr = u; cfg_llr = l; cfg_ccr = c; cfg_verify = v;
        cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(output int rel, output logic [1:0] st);
        logic seen = 1'b0;
        rel = -1;
        st  = 2'd0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                rel  = cyc - acc_cyc;
                st   = status;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    int         rel, b_wr, b_rd, b_st, b_cs;
    logic [1:0] st;
    logic [7:0] exp_d [4];

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_verify = 1'b0;
        cfg_plr = 8'd0; cfg_ulr = 8'd0; cfg_llr = 8'd0; cfg_ccr = 8'd0;
        for (int i = 0; i < 4; i++) mem[i] = 8'd0;

        // Reset state
        @(posedge clk); #1;
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("rst_ncs", 32'(bus_ncs), 32'd1);
        chk("rst_nwr", 32'(bus_nwr), 32'd1);
        chk("rst_nrd", 32'(bus_nrd), 32'd1);
        chk("rst_a_din", {22'd0, bus_a, bus_din}, 32'd0);
        chk("rst_start_busy_done", {29'd0, cnt_start, busy, done}, 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("cfg_ready_after_rst", 32'(cfg_ready), 32'd1);

        // Normal write, no verify
        ec_auto = 1'b1;
        b_wr = n_wr; b_rd = n_rd; b_st = n_start;
        send(8'd10, 8'd20, 8'd5, 8'd1, 1'b0);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_cfg_ready_low", 32'(cfg_ready), 32'd0);
        wait_done(rel, st);
        exp_d[0] = 8'd10; exp_d[1] = 8'd20; exp_d[2] = 8'd5; exp_d[3] = 8'd1;
        chk("t1_nwr", 32'(n_wr - b_wr), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_wr_a", 32'(wr_a[b_wr + i]), 32'(i));
            chk("t1_wr_d", 32'(wr_d[b_wr + i]), 32'(exp_d[i]));
            chk("t1_wr_rel", 32'(wr_rel[b_wr + i]), 32'(2 + i));
        end
        chk("t1_nrd", 32'(n_rd - b_rd), 32'd0);
        chk("t1_nstart", 32'(n_start - b_st), 32'd1);
        chk("t1_start_rel", 32'(start_rel), 32'd6);
        chk("t1_done_rel", 32'(rel), 32'd11);
        chk("t1_status", 32'(st), 32'd0);

        // Range error: plr above ulr
        b_st = n_start; b_cs = n_cs;
        send(8'd30, 8'd20, 8'd5, 8'd0, 1'b0);
        wait_done(rel, st);
        chk("t2_done_rel", 32'(rel), 32'd2);
        chk("t2_status", 32'(st), 32'd1);
        chk("t2_no_cs", 32'(n_cs - b_cs), 32'd0);
        chk("t2_no_start", 32'(n_start - b_st), 32'd0);
        @(posedge clk); #1;
        chk("t2_status_held", 32'(status), 32'd1);

        // Verify with corrupted ulr readback
        corrupt_ulr = 1'b1;
        b_wr = n_wr; b_rd = n_rd; b_st = n_start;
        send(8'h10, 8'h20, 8'h05, 8'h07, 1'b1);
        wait_done(rel, st);
        chk("t3_nwr", 32'(n_wr - b_wr), 32'd4);
        chk("t3_nrd", 32'(n_rd - b_rd), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t3_rd_a", 32'(rd_a[b_rd + i]), 32'(i));
            chk("t3_rd_rel", 32'(rd_rel[b_rd + i]), 32'(6 + i));
        end
        chk("t3_done_rel", 32'(rel), 32'd10);
        chk("t3_status", 32'(st), 32'd2);
        chk("t3_no_start", 32'(n_start - b_st), 32'd0);

        // Verify with clean readback
        corrupt_ulr = 1'b0;
        b_st = n_start;
        send(8'h10, 8'h20, 8'h05, 8'h07, 1'b1);
        wait_done(rel, st);
        chk("t3b_start_rel", 32'(start_rel), 32'd10);
        chk("t3b_nstart", 32'(n_start - b_st), 32'd1);
        chk("t3b_done_rel", 32'(rel), 32'd15);
        chk("t3b_status", 32'(st), 32'd0);

        // Timeout: end-of-count never arrives
        ec_auto = 1'b0;
        send(8'd10, 8'd20, 8'd5, 8'd1, 1'b0);
        wait_done(rel, st);
        chk("t4_start_rel", 32'(start_rel), 32'd6);
        chk("t4_done_rel", 32'(rel), 32'd23);
        chk("t4_status", 32'(st), 32'd3);

        // Stale end-of-count from before start, boundary plr=ulr=llr
        ec_force = 1'b1;
        @(posedge clk); #1;
        ec_force = 1'b0;
        chk("t5_ec_stuck", 32'(cnt_ec), 32'd1);
        ec_auto = 1'b1;
        b_st = n_start;
        send(8'h80, 8'h80, 8'h80, 8'h02, 1'b0);
        wait_done(rel, st);
        chk("t5_nstart", 32'(n_start - b_st), 32'd1);
        chk("t5_done_rel", 32'(rel), 32'd11);
        chk("t5_status", 32'(st), 32'd0);

        // Reset during WR2
        b_wr = n_wr;
        send(8'd40, 8'd50, 8'd30, 8'd3, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("t6_in_wr2", {30'd0, bus_a}, 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_ncs", 32'(bus_ncs), 32'd1);
        chk("t6_nwr", 32'(bus_nwr), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_ready_low", 32'(cfg_ready), 32'd0);
        @(posedge clk); #1;
        chk("t6_ready_high", 32'(cfg_ready), 32'd1);
        chk("t6_partial_writes", 32'(n_wr - b_wr), 32'd3);
        b_wr = n_wr; b_st = n_start;
        send(8'd10, 8'd20, 8'd5, 8'd1, 1'b0);
        wait_done(rel, st);
        chk("t6_new_nwr", 32'(n_wr - b_wr), 32'd4);
        chk("t6_new_start", 32'(n_start - b_st), 32'd1);
        chk("t6_new_status", 32'(st), 32'd0);

        chk("no_wr_rd_overlap", 32'(n_overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
